// File: rtl/seg_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned PTR_W      = 3;
  localparam int unsigned SEG_W      = 8;

  // All segments dark (active-low lines).
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // One register-file slot: decimal point plus hex nibble.
  typedef struct packed {
    logic       dot;
    logic [3:0] hex;
  } digit_t;

  // Scan slot phase: blanking gap first, then the digit is driven.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Decode a slot to active-low {dp,g,f,e,d,c,b,a}; dot set lights dp.
  function automatic logic [SEG_W-1:0] seg_decode(input digit_t d);
    logic [6:0] glyph;
    glyph = 7'h7F;
    case (d.hex)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
    return {~d.dot, glyph};
  endfunction

endpackage

// File: rtl/seg_wr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port with one-cycle acks.
module seg_wr_arbiter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt_c,
  output logic [1:0] o_ack
);

  logic [1:0] ack_q, ack_d;
  logic       prio_q, prio_d;  // 0: requester 0 wins a tie, 1: requester 1 wins
  logic [1:0] elig;

  // Mask requesters whose ack is showing, then pick one; priority only rotates on a tie.
  always_comb begin
    elig    = i_req & ~ack_q;
    o_gnt_c = 2'b00;
    prio_d  = prio_q;
    if (elig == 2'b11) begin
      o_gnt_c = prio_q ? 2'b10 : 2'b01;
      prio_d  = ~prio_q;
    end else begin
      o_gnt_c = elig;
    end
    ack_d = o_gnt_c;
  end

  // Ack follows grant by one cycle; reset drops any pending ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q  <= 2'b00;
      prio_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      prio_q <= prio_d;
    end
  end

  assign o_ack = ack_q;

endmodule

// File: rtl/seg_scan_scheduler.sv
// Eight-digit seven-segment scan controller with blanking gaps and an arbitrated write port.
module seg_scan_scheduler #(
  parameter int unsigned F_CLK     = 50000000,
  parameter int unsigned F_SCAN    = 1000,
  parameter int unsigned BLANK_CYC = 2500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_digit_en,
  input  logic [1:0] i_wr_req,
  input  logic [5:0] i_wr_addr,
  input  logic [9:0] i_wr_data,
  output logic [1:0] o_wr_ack,
  output logic [7:0] o_cs,
  output logic [7:0] o_dig_sel,
  output logic       o_frame
);
  import seg_pkg::*;

  localparam int unsigned DIV_DIGIT = F_CLK / F_SCAN;
  localparam int unsigned CNT_W     = (DIV_DIGIT > 1) ? $clog2(DIV_DIGIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_DIGIT - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  scan_state_e      state_q, state_d;
  logic [SEG_W-1:0] cs_q, cs_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             frame_q, frame_d;

  digit_t           slot_q [NUM_DIGITS];

  logic [1:0]       gnt_c;
  logic [PTR_W-1:0] wr_idx_c;
  digit_t           wr_digit_c;

  seg_wr_arbiter u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_wr_req),
    .o_gnt_c (gnt_c),
    .o_ack   (o_wr_ack)
  );

  // Route the granted requester's address and data to the write port.
  always_comb begin
    wr_idx_c   = i_wr_addr[2:0];
    wr_digit_c = digit_t'(i_wr_data[4:0]);
    if (gnt_c[1]) begin
      wr_idx_c   = i_wr_addr[5:3];
      wr_digit_c = digit_t'(i_wr_data[9:5]);
    end
  end

  // Register file: reset clears every slot and outranks a same-edge grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (gnt_c != 2'b00) begin
      slot_q[wr_idx_c] <= wr_digit_c;
    end
  end

  // Slot timing, pointer advance, blank/show phase and next output values.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    ptr_d   = ptr_q;
    frame_d = 1'b0;
    cs_d    = SEG_BLANK;
    seg_d   = SEG_BLANK;

    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      ptr_d   = ptr_q + PTR_W'(1);
      frame_d = (ptr_q == PTR_LAST);
    end

    // Phase register tracks cnt so it always describes the registered counter value.
    state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;

    if (state_q == ST_SHOW && i_digit_en[ptr_q]) begin
      cs_d  = ~(SEG_W'(1) << ptr_q);
      seg_d = seg_decode(slot_q[ptr_q]);
    end
  end

  // Scan state and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      ptr_q   <= '0;
      state_q <= ST_BLANK;
      cs_q    <= SEG_BLANK;
      seg_q   <= SEG_BLANK;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      state_q <= state_d;
      cs_q    <= cs_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign o_cs      = cs_q;
  assign o_dig_sel = seg_q;
  assign o_frame   = frame_q;

endmodule
